// File: rtl/vga_text_pkg.sv
// Shared constants and types for the VGA text-mode write front end:
// control codes, the default blank fill code and the writer FSM states.
package vga_text_pkg;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [7:0] BLANK_DEFAULT = 8'h20;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CLEAR_LINE   = 2'd1,
        CLEAR_SCREEN = 2'd2
    } state_t;

endpackage

// File: rtl/vga_text_cursor.sv
// Cursor position on the character grid plus row*COLS kept incrementally,
// so the writer never needs a multiplier to form addresses.
module vga_text_cursor #(
    parameter int COLS       = 210,
    parameter int ROWS       = 131,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_col_inc,
    input  logic                    i_col_dec,
    input  logic                    i_col_zero,
    input  logic                    i_row_adv,
    input  logic                    i_home,
    output logic [$clog2(COLS)-1:0] o_col,
    output logic [$clog2(ROWS)-1:0] o_row,
    output logic [ADDR_WIDTH-1:0]   o_row_base
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(COLS);

    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [ADDR_WIDTH-1:0] r_row_base;

    // Row base moves in lockstep with the row so it always equals row*COLS.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_home) begin
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else begin
            if (i_col_zero) begin
                r_col <= '0;
            end else if (i_col_inc) begin
                r_col <= r_col + COL_W'(1);
            end else if (i_col_dec) begin
                r_col <= r_col - COL_W'(1);
            end
            if (i_row_adv) begin
                if (r_row == LAST_ROW) begin
                    r_row      <= '0;
                    r_row_base <= '0;
                end else begin
                    r_row      <= r_row + ROW_W'(1);
                    r_row_base <= r_row_base + ROW_STEP;
                end
            end
        end
    end

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_row_base = r_row_base;

endmodule

// File: rtl/vga_text_writer.sv
// Byte-stream front end for the text-mode character memory: turns a
// ready/valid character stream into write strobes and blanking sweeps.
module vga_text_writer
    import vga_text_pkg::*;
#(
    parameter int         COLS       = 210,
    parameter int         ROWS       = 131,
    parameter int         ADDR_WIDTH = 15,
    parameter logic [7:0] BLANK      = BLANK_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_in_valid,
    input  logic [7:0]              i_in_char,
    output logic                    o_in_ready,
    output logic [ADDR_WIDTH-1:0]   o_wr_addr,
    output logic [7:0]              o_wr_data,
    output logic                    o_wr_en,
    output logic [$clog2(COLS)-1:0] o_cursor_col,
    output logic [$clog2(ROWS)-1:0] o_cursor_row
);

    localparam int COL_W = $clog2(COLS);
    localparam int CNT_W = $clog2(COLS * ROWS + 1);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0] LINE_END   = CNT_W'(COLS);
    localparam logic [CNT_W-1:0] SCREEN_END = CNT_W'(COLS * ROWS);

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  r_wr_en;
    logic                  w_wr_en_next;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] w_wr_addr_next;
    logic [7:0]            r_wr_data;
    logic [7:0]            w_wr_data_next;

    logic                  w_col_inc;
    logic                  w_col_dec;
    logic                  w_col_zero;
    logic                  w_row_adv;
    logic                  w_home;
    logic [COL_W-1:0]      w_col;
    logic [ADDR_WIDTH-1:0] w_row_base;
    logic [ADDR_WIDTH-1:0] w_cur_addr;

    vga_text_cursor #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cursor (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_col_inc  (w_col_inc),
        .i_col_dec  (w_col_dec),
        .i_col_zero (w_col_zero),
        .i_row_adv  (w_row_adv),
        .i_home     (w_home),
        .o_col      (w_col),
        .o_row      (o_cursor_row),
        .o_row_base (w_row_base)
    );

    assign w_cur_addr = w_row_base + ADDR_WIDTH'(w_col);

    // Reset lands in CLEAR_SCREEN so the display is blanked after power-up.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= CLEAR_SCREEN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Each clear runs one extra counter step past its last write, which holds
    // in_ready low for the cycle in which that last write is on the port.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_wr_en_next   = 1'b0;
        w_wr_addr_next = r_wr_addr;
        w_wr_data_next = r_wr_data;
        w_col_inc      = 1'b0;
        w_col_dec      = 1'b0;
        w_col_zero     = 1'b0;
        w_row_adv      = 1'b0;
        w_home         = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_in_valid) begin
                    w_cnt_next = '0;
                    if (i_in_char >= 8'h20) begin
                        w_wr_en_next   = 1'b1;
                        w_wr_addr_next = w_cur_addr;
                        w_wr_data_next = i_in_char;
                        if (w_col == LAST_COL) begin
                            w_col_zero   = 1'b1;
                            w_row_adv    = 1'b1;
                            w_state_next = CLEAR_LINE;
                        end else begin
                            w_col_inc = 1'b1;
                        end
                    end else begin
                        case (i_in_char)
                            CH_LF: begin
                                w_col_zero   = 1'b1;
                                w_row_adv    = 1'b1;
                                w_state_next = CLEAR_LINE;
                            end
                            CH_CR: w_col_zero = 1'b1;
                            CH_BS: begin
                                if (w_col != '0) begin
                                    w_col_dec      = 1'b1;
                                    w_wr_en_next   = 1'b1;
                                    w_wr_addr_next = w_cur_addr - ADDR_WIDTH'(1);
                                    w_wr_data_next = BLANK;
                                end
                            end
                            CH_FF: begin
                                w_home       = 1'b1;
                                w_state_next = CLEAR_SCREEN;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR_LINE: begin
                if (r_cnt == LINE_END) begin
                    w_state_next = IDLE;
                end else begin
                    w_wr_en_next   = 1'b1;
                    w_wr_addr_next = w_row_base + ADDR_WIDTH'(r_cnt);
                    w_wr_data_next = BLANK;
                    w_cnt_next     = r_cnt + CNT_W'(1);
                end
            end
            CLEAR_SCREEN: begin
                if (r_cnt == SCREEN_END) begin
                    w_state_next = IDLE;
                end else begin
                    w_wr_en_next   = 1'b1;
                    w_wr_addr_next = ADDR_WIDTH'(r_cnt);
                    w_wr_data_next = BLANK;
                    w_cnt_next     = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_next = CLEAR_SCREEN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en   <= w_wr_en_next;
            r_wr_addr <= w_wr_addr_next;
            r_wr_data <= w_wr_data_next;
        end
    end

    assign o_in_ready   = (r_state == IDLE);
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_cursor_col = w_col;

endmodule

// File: tb/tb_vga_text_writer.sv
// Scoreboard bench for vga_text_writer on a 4x3 grid: a grid-level model
// predicts every memory write with its cycle, the busy span of every clear
// and the cursor, while a negedge monitor checks what the DUT presents.
module tb_vga_text_writer;

    localparam int         COLS        = 4;
    localparam int         ROWS        = 3;
    localparam int         ADDR_WIDTH  = 4;
    localparam int         CELLS       = COLS * ROWS;
    localparam logic [7:0] BLANK       = 8'h20;
    localparam int         WAIT_BUDGET = 100;

    logic                  clk     = 1'b0;
    logic                  reset   = 1'b1;
    logic                  inValid = 1'b0;
    logic [7:0]            inChar  = 8'h00;
    logic                  inReady;
    logic [ADDR_WIDTH-1:0] wrAddr;
    logic [7:0]            wrData;
    logic                  wrEn;
    logic [1:0]            cursorCol;
    logic [1:0]            cursorRow;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } write_t;

    write_t expQ[$];
    int     busyQ[$];
    int     expCol;
    int     expRow;
    int     cyc;
    int     runLen;
    int     nVectors;
    int     nMiscompares;

    vga_text_writer #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BLANK      (BLANK)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_in_valid   (inValid),
        .i_in_char    (inChar),
        .o_in_ready   (inReady),
        .o_wr_addr    (wrAddr),
        .o_wr_data    (wrData),
        .o_wr_en      (wrEn),
        .o_cursor_col (cursorCol),
        .o_cursor_row (cursorRow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nVectors++;
        if (actual != expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: actual %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushBlankRange(input int firstAddr, input int count, input int startCyc);
        for (int k = 0; k < count; k++) begin
            expQ.push_back('{firstAddr + k, int'(BLANK), startCyc + k});
        end
    endtask

    // Grid-level behaviour: a new row is blanked right after any row advance.
    task automatic modelRowAdvance(input int t);
        expRow = (expRow + 1) % ROWS;
        pushBlankRange(expRow * COLS, COLS, t + 1);
        busyQ.push_back(COLS + 1);
    endtask

    // Called just after the accepting edge; t is the cycle holding the direct write.
    task automatic modelAccept(input logic [7:0] c);
        int t;
        t = cyc;
        if (c >= 8'h20) begin
            expQ.push_back('{expRow * COLS + expCol, int'(c), t});
            if (expCol < COLS - 1) begin
                expCol++;
            end else begin
                expCol = 0;
                modelRowAdvance(t);
            end
        end else if (c == 8'h0A) begin
            expCol = 0;
            modelRowAdvance(t);
        end else if (c == 8'h0D) begin
            expCol = 0;
        end else if (c == 8'h08) begin
            if (expCol > 0) begin
                expCol--;
                expQ.push_back('{expRow * COLS + expCol, int'(BLANK), t});
            end
        end else if (c == 8'h0C) begin
            expCol = 0;
            expRow = 0;
            pushBlankRange(0, CELLS, t + 1);
            busyQ.push_back(CELLS + 1);
        end
    endtask

    // Offers c; while the DUT is busy, in_char carries junk that must be ignored.
    task automatic applyStimulus(input logic [7:0] c);
        int waited;
        waited  = 0;
        inValid = 1'b1;
        inChar  = c;
        @(negedge clk);
        while (!inReady && waited < WAIT_BUDGET) begin
            inChar = 8'($urandom_range(0, 255));
            waited++;
            @(negedge clk);
        end
        if (!inReady) begin
            checkOutput("readyTimeout", int'(inReady), 1);
            inValid = 1'b0;
            return;
        end
        inChar = c;
        @(posedge clk);
        #1;
        modelAccept(c);
        inValid = 1'b0;
        inChar  = 8'($urandom_range(0, 255));
    endtask

    task automatic applyIdle(input int n);
        inValid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int n);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        inValid = 1'b0;
        expQ.delete();
        busyQ.delete();
        expCol = 0;
        expRow = 0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        pushBlankRange(0, CELLS, cyc + 1);
        busyQ.push_back(CELLS + 1);
    endtask

    // Monitor: pops the scoreboard on each write, tracks busy spans and cursor.
    always @(negedge clk) begin
        write_t e;
        if (reset) begin
            runLen = 0;
        end else begin
            if (wrEn) begin
                checkOutput("addrInRange", int'(wrAddr < CELLS), 1);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedWrite", int'(wrAddr), -1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wrAddr", int'(wrAddr), e.addr);
                    checkOutput("wrData", int'(wrData), e.data);
                    checkOutput("wrCycle", cyc, e.cyc);
                end
            end
            if (!inReady) begin
                runLen++;
            end else if (runLen > 0) begin
                if (busyQ.size() == 0) begin
                    checkOutput("unexpectedBusy", runLen, 0);
                end else begin
                    checkOutput("busyCycles", runLen, busyQ.pop_front());
                end
                runLen = 0;
            end
            checkOutput("cursorCol", int'(cursorCol), expCol);
            checkOutput("cursorRow", int'(cursorRow), expRow);
        end
    end

    initial begin
        int r;
        int guard;
        logic [7:0] c;

        applyReset(3);
        @(negedge clk);
        checkOutput("resetWrEn", int'(wrEn), 0);
        checkOutput("resetWrAddr", int'(wrAddr), 0);
        checkOutput("resetWrData", int'(wrData), 0);
        checkOutput("resetInReady", int'(inReady), 0);
        applyIdle(14);

        applyStimulus(8'h41);
        applyStimulus(8'h42);
        applyIdle(2);

        applyReset(2);
        applyIdle(14);
        applyStimulus(8'h41);
        applyStimulus(8'h42);
        applyStimulus(8'h43);
        applyStimulus(8'h44);
        applyIdle(7);

        applyStimulus(8'h08);
        applyStimulus(8'h58);
        applyStimulus(8'h08);
        applyIdle(2);

        applyStimulus(8'h0A);
        applyIdle(7);
        applyStimulus(8'h0A);
        applyIdle(7);

        applyStimulus(8'h48);
        applyStimulus(8'h49);
        applyStimulus(8'h0C);
        applyStimulus(8'h51);
        applyIdle(3);

        applyStimulus(8'h0C);
        applyIdle(4);
        applyReset(1);
        applyIdle(14);

        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                c = 8'($urandom_range(32, 255));
            end else if (r < 72) begin
                c = 8'h0A;
            end else if (r < 80) begin
                c = 8'h0D;
            end else if (r < 90) begin
                c = 8'h08;
            end else if (r < 92) begin
                c = 8'h0C;
            end else begin
                c = 8'($urandom_range(0, 31));
                if (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D) c = 8'h01;
            end
            applyStimulus(c);
            if ($urandom_range(0, 4) == 0) applyIdle($urandom_range(1, 3));
        end

        guard = 0;
        while ((expQ.size() > 0 || !inReady) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        applyIdle(2);
        checkOutput("pendingWrites", expQ.size(), 0);
        checkOutput("pendingBusy", busyQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/vga_text_writer.md
# vga_text_writer

Byte-stream front end that drives the character-memory write port of the VGA text-mode display (write address, write data, write enable). It accepts one character per ready/valid handshake and tracks a cursor on the COLS×ROWS grid. Printable characters become single memory writes; control characters move the cursor or trigger blanking sequences. It runs in the CPU clock domain and replaces direct CPU stores to the display's write port.

## Interface
- COLS, 210, characters per row (h_disp/8)
- ROWS, 131, character rows (v_disp/8)
- ADDR_WIDTH, 15, write-address width; must satisfy 2^ADDR_WIDTH ≥ COLS*ROWS
- BLANK, 8'h20, fill code used by all clears and backspace
- clk  in  1  CPU clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  in_char is offered
- in_char  in  8  character code
- in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready
- wr_addr  out  ADDR_WIDTH  character-memory address, row*COLS+col
- wr_data  out  8  character code to store
- wr_en  out  1  one-cycle write strobe; addr/data valid while high
- cursor_col  out  $clog2(COLS)  current column
- cursor_row  out  $clog2(ROWS)  current row

## Operation
- FSM states: IDLE, CLEAR_LINE, CLEAR_SCREEN. in_ready = (state == IDLE), decoded from registered state.
- Reset: enter CLEAR_SCREEN with cursor (0,0), clear counter 0, wr_en=0, wr_addr=0, wr_data=0, in_ready=0.
- Accepted codes:
  - 0x20–0xFF: write code at (row,col). If col < COLS-1, then col++. Otherwise col=0 and a row advance occurs.
  - 0x0A LF: col=0, row advance.
  - 0x0D CR: col=0, no write.
  - 0x08 BS: if col > 0, col-- and write BLANK at the new position; at col 0, no effect.
  - 0x0C FF: cursor (0,0), enter CLEAR_SCREEN.
  - Other codes below 0x20: accepted and ignored.
- Row advance: row = (row==ROWS-1) ? 0 : row+1, then enter CLEAR_LINE. There is no scrolling because the port is write-only. The new row is blanked instead.
- CLEAR_LINE: writes BLANK to cols 0..COLS-1 of the new row, one per cycle, then returns to IDLE.
- CLEAR_SCREEN: writes BLANK to addresses 0..COLS*ROWS-1, one per cycle, then returns to IDLE.
- Address arithmetic: no multiplier. A row_base register holds row*COLS. It is updated by +COLS, wraps to 0 together with row, and is reset to 0. wr_addr = row_base + col, truncated to ADDR_WIDTH. No address ever exceeds COLS*ROWS-1.

## Timing
- All outputs are registered.
- A character accepted in cycle N produces its write (wr_en=1) in cycle N+1.
- When the acceptance triggers CLEAR_LINE or CLEAR_SCREEN, in_ready is 0 from N+1.
- CLEAR_LINE writes appear in cycles N+2..N+1+COLS. in_ready=1 again at N+2+COLS.
- For LF, cycle N+1 carries no write. Its clear still starts at N+2.
- CLEAR_SCREEN after FF: writes in N+2..N+1+COLS*ROWS; in_ready at N+2+COLS*ROWS.
- CLEAR_SCREEN after reset: with reset deasserted at cycle 0, writes occur in cycles 1..COLS*ROWS. in_ready=1 at COLS*ROWS+1.
- Back-to-back printable characters sustain one write per cycle.
- in_valid while in_ready=0: no transfer, and in_char is ignored.
- Reset asserted mid-clear or mid-handshake aborts the operation and restarts the post-reset CLEAR_SCREEN. A partially blanked screen is acceptable.
- cursor_col/cursor_row update in cycle N+1 and are stable during clears.

## Structure
- Package vga_text_pkg holds:
  - control codes: CH_BS=8'h08, CH_LF=8'h0A, CH_FF=8'h0C, CH_CR=8'h0D
  - BLANK default
  - FSM state enum
- Sub-module vga_text_cursor holds col, row, and row_base with their advance and wrap logic. Its commands are col_inc, col_dec, col_zero, row_adv, home.

## Test plan
Parameters for all scenarios: COLS=4, ROWS=3, ADDR_WIDTH=4.
- Reset, then release → 12 writes, addr 0..11, data 0x20, in cycles 1..12; in_ready=1 at cycle 13; cursor (0,0).
- Send 'A','B' back-to-back → writes (0,0x41), (1,0x42) in consecutive cycles; cursor (2,0).
- Send 'A','B','C','D' → writes to addr 0..3, then clear writes to addr 4..7 with data 0x20; cursor (0,1); in_ready low for 5 cycles.
- BS handling:
  - BS at col 0 → no write, cursor unchanged.
  - 'X' then BS → write (0,0x58), then write (0,0x20); cursor (0,0).
- Row wrap: cursor at row 2, send LF → cursor (0,0); clear writes to addr 0..3; addr never reaches 12.
- FF mid-line with in_valid held high → 12 clear writes; no transfer while in_ready=0. The next character is written at addr 0. Reset asserted during the clear restarts it at addr 0.
